// File: rtl/instr_dcd_pkg.sv
// rtl/instr_dcd_pkg.sv - shared types and constants for the SPI command decoder
package instr_dcd_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int CMD_HL_BIT = 6;
    localparam int ADDR_W     = 6;

    typedef enum logic [2:0] {
        ST_CMD      = 3'd0,
        ST_WDATA    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_CAP   = 3'd3,
        ST_RDUMMY   = 3'd4
    } state_e;

    // High-byte select addresses base+1; the 6-bit sum wraps 0x3F+1 to 0x00.
    function automatic logic [ADDR_W-1:0] eff_addr(input logic [7:0] cmd);
        return cmd[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, cmd[CMD_HL_BIT]};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - two-byte SPI frame decoder driving register read/write strobes
module instr_decoder
    import instr_dcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_write,
    input  logic [7:0]        data_read,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_write_q, data_write_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        data_out_d   = data_out_q;
        read_d       = 1'b0;
        write_d      = 1'b0;

        // Deselect aborts any frame and drops a coincident byte.
        if (cs_n) begin
            state_d    = ST_CMD;
            data_out_d = 8'h00;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (byte_sync) begin
                        addr_d = eff_addr(data_in);
                        if (data_in[CMD_RW_BIT]) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d = ST_RD_ISSUE;
                            read_d  = 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (byte_sync) begin
                        write_d      = 1'b1;
                        data_write_d = data_in;
                        state_d      = ST_CMD;
                    end
                end
                ST_RD_ISSUE: state_d = ST_RD_CAP;
                ST_RD_CAP: begin
                    data_out_d = data_read;
                    state_d    = ST_RDUMMY;
                end
                ST_RDUMMY: begin
                    if (byte_sync) begin
                        data_out_d = 8'h00;
                        state_d    = ST_CMD;
                    end
                end
                default: state_d = ST_CMD;
            endcase
        end

        busy_d = (state_d != ST_CMD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CMD;
            addr_q       <= '0;
            data_write_q <= 8'h00;
            data_out_q   <= 8'h00;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            data_out_q   <= data_out_d;
            read_q       <= read_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - scoreboard bench for instr_decoder
module tb_instr_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read = 8'h00;
    logic       busy;

    logic [7:0] regs [64];

    typedef struct {
        bit         is_write;
        logic [5:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    instr_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read) data_read <= regs[addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Strobe monitor: every read/write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (read || write)) begin
            check("strobe_exclusive", {31'd0, read & write}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, read, write}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {31'd0, write}, {31'd0, e.is_write});
                check("strobe_addr", {26'd0, addr}, {26'd0, e.a});
                if (e.is_write) check("strobe_wdata", {24'd0, data_write}, {24'd0, e.d});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte for a single cycle; returns 1ns into the cycle after it.
    task automatic send_byte(input logic [7:0] b);
        data_in   = b;
        byte_sync = 1'b1;
        tick(1);
        byte_sync = 1'b0;
    endtask

    task automatic push_exp(input bit w, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        e.is_write = w;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 8'(i * 3);
        regs[6'h0D] = 8'hA5;
        regs[6'h05] = 8'h3C;

        tick(2);
        check("reset_read", {31'd0, read}, 32'd0);
        check("reset_write", {31'd0, write}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_addr", {26'd0, addr}, 32'd0);
        check("reset_data_write", {24'd0, data_write}, 32'd0);
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        cs_n = 1'b0;
        tick(1);

        // Write 0x5A to 0x02
        send_byte(8'h82);
        check("wr_busy", {31'd0, busy}, 32'd1);
        tick(2);
        push_exp(1'b1, 6'h02, 8'h5A);
        send_byte(8'h5A);
        check("wr_latency", {31'd0, write}, 32'd1);
        tick(1);
        check("wr_single_pulse", {31'd0, write}, 32'd0);
        check("wr_addr_hold", {26'd0, addr}, 32'h02);
        check("wr_data_hold", {24'd0, data_write}, 32'h5A);
        check("wr_idle_busy", {31'd0, busy}, 32'd0);

        // Read 0x0D -> 0xA5
        push_exp(1'b0, 6'h0D, 8'h00);
        send_byte(8'h0D);
        check("rd_latency", {31'd0, read}, 32'd1);
        tick(1);
        check("rd_single_pulse", {31'd0, read}, 32'd0);
        check("rd_dout_not_yet", {24'd0, data_out}, 32'd0);
        tick(1);
        check("rd_dout_n3", {24'd0, data_out}, 32'hA5);
        tick(3);
        check("rd_dout_held", {24'd0, data_out}, 32'hA5);
        check("rd_busy_dummy", {31'd0, busy}, 32'd1);
        send_byte(8'h33);
        check("rd_dout_cleared", {24'd0, data_out}, 32'd0);
        check("rd_busy_done", {31'd0, busy}, 32'd0);

        // High-byte select and wrap, back-to-back bytes
        send_byte(8'hC3);
        push_exp(1'b1, 6'h04, 8'h77);
        send_byte(8'h77);
        send_byte(8'hFF);
        push_exp(1'b1, 6'h00, 8'h99);
        send_byte(8'h99);
        tick(1);
        check("wrap_addr", {26'd0, addr}, 32'h00);

        // Abort before the data byte
        send_byte(8'h85);
        tick(1);
        cs_n = 1'b1;
        tick(1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        cs_n = 1'b0;
        tick(1);
        send_byte(8'h80);
        push_exp(1'b1, 6'h00, 8'h11);
        send_byte(8'h11);
        tick(1);

        // cs_n and data byte_sync in the same cycle
        send_byte(8'h86);
        cs_n      = 1'b1;
        data_in   = 8'h22;
        byte_sync = 1'b1;
        tick(1);
        byte_sync = 1'b0;
        check("collide_write", {31'd0, write}, 32'd0);
        check("collide_busy", {31'd0, busy}, 32'd0);
        cs_n = 1'b0;
        tick(2);

        // Reset while in RD_CAP
        push_exp(1'b0, 6'h05, 8'h00);
        send_byte(8'h05);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {26'd0, addr}, 32'd0);
        check("rst_data_write", {24'd0, data_write}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_strobes", {30'd0, read, write}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        push_exp(1'b0, 6'h05, 8'h00);
        send_byte(8'h05);
        tick(2);
        check("rd2_dout", {24'd0, data_out}, 32'h3C);
        send_byte(8'h00);
        check("rd2_dout_cleared", {24'd0, data_out}, 32'd0);
        tick(3);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
